// File: rtl/traffic_pkg.sv
// Shared lamp encodings and phase type for the intersection phase scheduler.
package traffic_pkg;

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_GREEN  = 2'b01;
  localparam logic [1:0] LAMP_YELLOW = 2'b10;

  typedef enum logic [1:0] {
    PH_GREEN,
    PH_YELLOW,
    PH_ALLRED
  } phase_t;

endpackage

// File: rtl/rr_next_picker.sv
// Circular priority search: first set request bit at or after start, wrapping to 0.
module rr_next_picker #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] start,
  output logic [IDW-1:0] idx,
  output logic           found
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(start) + i) % N]) begin
        found = 1'b1;
        idx   = IDW'((int'(start) + i) % N);
      end
    end
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Round-robin green/yellow/all-red sequencer for N approaches with min/max green
// and emergency preempt; all timing advances on the slow tick enable.
module intersection_phase_scheduler
  import traffic_pkg::*;
#(
  parameter  int N_APPR     = 4,
  parameter  int MIN_GREEN  = 4,
  parameter  int MAX_GREEN  = 12,
  parameter  int YELLOW_CYC = 3,
  parameter  int ALLRED_CYC = 2,
  localparam int IDW        = $clog2(N_APPR)
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                tick,
  input  logic [N_APPR-1:0]   req,
  input  logic                preempt_valid,
  input  logic [IDW-1:0]      preempt_id,
  output logic [2*N_APPR-1:0] light,
  output logic [IDW-1:0]      active_id,
  output logic                phase_start
);

  localparam int CW = $clog2(MAX_GREEN + 1);
  localparam logic [CW-1:0] MIN_LAST = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] MAX_LAST = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] YEL_LAST = CW'(YELLOW_CYC - 1);
  localparam logic [CW-1:0] AR_LAST  = CW'(ALLRED_CYC - 1);

  phase_t          phase;
  logic [IDW-1:0]  next_id;
  logic [CW-1:0]   cnt;

  logic [N_APPR-1:0] other_req;
  logic [IDW-1:0]    scan_start;
  logic [IDW-1:0]    pick_id;
  logic              pick_found;
  logic              pre_ok;
  logic [CW-1:0]     cnt_sat;

  assign other_req  = req & ~(N_APPR'(1) << active_id);
  assign scan_start = (int'(active_id) == N_APPR - 1) ? '0 : active_id + 1'b1;
  // Out-of-range preempt ids are dropped as if no preempt were present.
  assign pre_ok     = preempt_valid && (int'(preempt_id) < N_APPR);
  assign cnt_sat    = (cnt >= MAX_LAST) ? MAX_LAST : cnt + 1'b1;

  rr_next_picker #(.N(N_APPR)) u_picker (
    .req   (other_req),
    .start (scan_start),
    .idx   (pick_id),
    .found (pick_found)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (clear) begin
      phase       <= PH_GREEN;
      active_id   <= '0;
      next_id     <= '0;
      cnt         <= '0;
      phase_start <= 1'b0;
    end else begin
      phase_start <= 1'b0;
      if (tick) begin
        case (phase)
          PH_GREEN: begin
            if (pre_ok && preempt_id == active_id) begin
              cnt <= cnt_sat;
            end else if (pre_ok) begin
              phase   <= PH_YELLOW;
              next_id <= preempt_id;
              cnt     <= '0;
            end else if (pick_found && cnt >= MIN_LAST &&
                         (!req[active_id] || cnt >= MAX_LAST)) begin
              phase   <= PH_YELLOW;
              next_id <= pick_id;
              cnt     <= '0;
            end else begin
              cnt <= cnt_sat;
            end
          end
          PH_YELLOW: begin
            if (pre_ok) next_id <= preempt_id;
            if (cnt == YEL_LAST) begin
              phase <= PH_ALLRED;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PH_ALLRED: begin
            if (cnt == AR_LAST) begin
              // A preempt seen on the final clearance tick still wins the next green.
              phase       <= PH_GREEN;
              active_id   <= pre_ok ? preempt_id : next_id;
              next_id     <= pre_ok ? preempt_id : next_id;
              cnt         <= '0;
              phase_start <= 1'b1;
            end else begin
              if (pre_ok) next_id <= preempt_id;
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            phase <= PH_GREEN;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    light = '0;
    case (phase)
      PH_GREEN:  light[2*int'(active_id) +: 2] = LAMP_GREEN;
      PH_YELLOW: light[2*int'(active_id) +: 2] = LAMP_YELLOW;
      default:   light = '0;
    endcase
  end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed-vector bench for intersection_phase_scheduler at default parameters.
module tb_intersection_phase_scheduler;

  logic       clock = 1'b0;
  logic       clear;
  logic       tick;
  logic [3:0] req;
  logic       preempt_valid;
  logic [1:0] preempt_id;
  logic [7:0] light;
  logic [1:0] active_id;
  logic       phase_start;

  int n_vec = 0;
  int n_err = 0;

  intersection_phase_scheduler dut (
    .clock         (clock),
    .clear         (clear),
    .tick          (tick),
    .req           (req),
    .preempt_valid (preempt_valid),
    .preempt_id    (preempt_id),
    .light         (light),
    .active_id     (active_id),
    .phase_start   (phase_start)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] r);
    clear         = 1'b1;
    tick          = 1'b1;
    req           = 4'b0000;
    preempt_valid = 1'b0;
    preempt_id    = 2'd0;
    step();
    clear = 1'b0;
    req   = r;
  endtask

  task automatic wait_start(input string tag, input int exp_cycles, input int exp_id);
    int n = 0;
    while (!phase_start && n < 40) begin
      step();
      n++;
    end
    check({tag, "_cycles"}, n, exp_cycles);
    check({tag, "_id"}, {30'd0, active_id}, exp_id);
  endtask

  logic [7:0] s2_light [10] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02,
                                8'h02, 8'h02, 8'h00, 8'h00, 8'h10};

  initial begin
    // 1: idle after reset, approach 0 rests in green
    do_reset(4'b0000);
    check("s1_active", {30'd0, active_id}, 0);
    for (int k = 0; k < 30; k++) begin
      check("s1_light", {24'd0, light}, 8'h01);
      check("s1_start", {31'd0, phase_start}, 0);
      step();
    end

    // 2: single request on approach 2
    do_reset(4'b0100);
    for (int k = 0; k < 10; k++) begin
      check("s2_light", {24'd0, light}, s2_light[k]);
      check("s2_start", {31'd0, phase_start}, (k == 9) ? 1 : 0);
      if (k < 9) step();
    end
    check("s2_active", {30'd0, active_id}, 2);
    step();
    check("s2_start_pulse", {31'd0, phase_start}, 0);

    // 3: round-robin from approach 1 picks 3 before 0
    do_reset(4'b0010);
    wait_start("s3_to1", 9, 1);
    req = 4'b1001;
    step();
    wait_start("s3_to3", 8, 3);
    check("s3_light3", {24'd0, light}, 8'h40);
    req = 4'b0001;
    step();
    wait_start("s3_to0", 8, 0);
    check("s3_light0", {24'd0, light}, 8'h01);

    // 4: max-green cap with both approaches requesting
    do_reset(4'b0011);
    repeat (11) step();
    check("s4_green_last", {24'd0, light}, 8'h01);
    step();
    check("s4_yellow", {24'd0, light}, 8'h02);
    repeat (4) step();
    check("s4_allred", {24'd0, light}, 8'h00);
    step();
    check("s4_light1", {24'd0, light}, 8'h04);
    check("s4_start", {31'd0, phase_start}, 1);
    check("s4_active", {30'd0, active_id}, 1);

    // 5: preempt to approach 3 ignores min green, then holds green
    do_reset(4'b0000);
    step();
    preempt_valid = 1'b1;
    preempt_id    = 2'd3;
    step();
    check("s5_yellow_first", {24'd0, light}, 8'h02);
    repeat (2) step();
    check("s5_yellow_last", {24'd0, light}, 8'h02);
    step();
    check("s5_allred_first", {24'd0, light}, 8'h00);
    step();
    check("s5_allred_last", {24'd0, light}, 8'h00);
    step();
    check("s5_light3", {24'd0, light}, 8'h40);
    check("s5_start", {31'd0, phase_start}, 1);
    check("s5_active", {30'd0, active_id}, 3);
    req = 4'b0111;
    for (int k = 0; k < 20; k++) begin
      step();
      check("s5_hold", {24'd0, light}, 8'h40);
    end
    preempt_valid = 1'b0;
    step();
    check("s5_release_yellow", {24'd0, light}, 8'h80);
    wait_start("s5_to0", 5, 0);

    // 6: clear mid-yellow, then tick freeze inside yellow
    do_reset(4'b0100);
    wait_start("s6_to2", 9, 2);
    req = 4'b0001;
    repeat (5) step();
    check("s6_mid_yellow", {24'd0, light}, 8'h20);
    clear = 1'b1;
    step();
    clear = 1'b0;
    req   = 4'b0010;
    check("s6_reset_light", {24'd0, light}, 8'h01);
    check("s6_reset_active", {30'd0, active_id}, 0);
    check("s6_reset_start", {31'd0, phase_start}, 0);
    repeat (3) step();
    check("s6_green_last", {24'd0, light}, 8'h01);
    step();
    check("s6_yellow", {24'd0, light}, 8'h02);
    tick = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("s6_frozen", {24'd0, light}, 8'h02);
    end
    tick = 1'b1;
    step();
    check("s6_tick1", {24'd0, light}, 8'h02);
    step();
    check("s6_tick2", {24'd0, light}, 8'h02);
    step();
    check("s6_tick3_allred", {24'd0, light}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
